// File: rtl/stim_capture_responder_if.sv
// Load/number stimulus bus plus the read/dump side of the capture responder.
// The master end belongs to the bench or stimulus generator, the slave end to the responder.
interface stim_capture_responder_if #(
   parameter int WIDTH = 8,
   parameter int PTR_W = 3
);
   logic             load;
   logic [WIDTH-1:0] number_in;
   logic             rd_req;
   logic             dump;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             busy;
   logic             dump_done;
   logic [PTR_W-1:0] count;
   logic             full;
   logic             empty;
   logic             overflow;
   logic             underflow;

   modport master (
      output load, number_in, rd_req, dump,
      input  rd_data, rd_valid, busy, dump_done, count, full, empty, overflow, underflow
   );

   modport slave (
      input  load, number_in, rd_req, dump,
      output rd_data, rd_valid, busy, dump_done, count, full, empty, overflow, underflow
   );
endinterface

// File: rtl/stim_capture_responder.sv
// Captures stimulus bytes into a small circular store and returns them one at a time
// on rd_req, or as a back-to-back burst on dump.
module stim_capture_responder #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 5,
   parameter int PTR_W = 3
) (
   input logic                     clk,
   input logic                     reset,
   stim_capture_responder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;

   localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

   state_t           state, state_next;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr, count, count_next, remaining;
   logic [WIDTH-1:0] rd_data_q;
   logic             rd_valid_q, full_q, empty_q, overflow_q, underflow_q;

   logic rd_go, wr_go, ovf_set, unf_set, dump_start;

   // DEPTH need not be a power of two, so wrap explicitly instead of relying on rollover.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_P) ? '0 : p + PTR_W'(1);
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // NOTE: each variable assigned in always_comb gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (bus.dump) state_next = (count != '0) ? DUMP : DONE;
         DUMP: if (remaining == PTR_W'(1)) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Dump entry performs the first read itself, so a burst's data begins the cycle after dump.
   always_comb begin
      rd_go      = 1'b0;
      unf_set    = 1'b0;
      dump_start = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.dump) begin
               rd_go      = (count != '0);
               dump_start = (count != '0);
            end else if (bus.rd_req) begin
               rd_go   = (count != '0);
               unf_set = (count == '0);
            end
         end
         DUMP:    rd_go = (remaining != PTR_W'(1));
         default: rd_go = 1'b0;
      endcase
      // A read in the same cycle frees a slot, so a load while full still lands.
      wr_go   = bus.load && (!full_q || rd_go);
      ovf_set = bus.load && full_q && !rd_go;
   end

   always_comb begin
      count_next = count;
      unique case ({wr_go, rd_go})
         2'b10:   count_next = count + PTR_W'(1);
         2'b01:   count_next = count - PTR_W'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         remaining   <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_go) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_go) begin
            rd_ptr    <= ptr_inc(rd_ptr);
            rd_data_q <= mem[rd_ptr];
         end
         rd_valid_q <= rd_go;
         count      <= count_next;
         full_q     <= (count_next == DEPTH_P);
         empty_q    <= (count_next == '0);
         // remaining counts the entries of the burst still to be shown, including the current one.
         if (dump_start)          remaining <= count;
         else if (state == DUMP)  remaining <= remaining - PTR_W'(1);
         if (ovf_set) overflow_q  <= 1'b1;
         if (unf_set) underflow_q <= 1'b1;
      end
   end

   // NOTE: the storage array has no reset; the pointers and count define which entries are
   // live, so stale contents are never observable.
   always_ff @(posedge clk) begin
      if (wr_go) mem[wr_ptr] <= bus.number_in;
   end

   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.busy      = (state != IDLE);
   assign bus.dump_done = (state == DONE);
   assign bus.count     = count;
   assign bus.full      = full_q;
   assign bus.empty     = empty_q;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_stim_capture_responder.sv
// Directed bench for stim_capture_responder: single reads, overflow, wrap, full read+write,
// underflow, empty dump and reset during a dump, with hand-computed expectations.
module tb_stim_capture_responder;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   stim_capture_responder_if #(.WIDTH(8), .PTR_W(3)) sif ();

   stim_capture_responder #(.WIDTH(8), .DEPTH(5), .PTR_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sif)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_bytes(input logic [7:0] first, input int n);
      sif.load = 1'b1;
      for (int i = 0; i < n; i++) begin
         sif.number_in = first + 8'(i);
         tick();
      end
      sif.load = 1'b0;
   endtask

   // dump is held for two cycles; the second cycle lands while busy and must be ignored.
   task automatic dump_and_check(input string tag, input logic [7:0] e [5]);
      sif.dump = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 1) sif.dump = 1'b0;
         check({tag, "_valid"}, 32'(sif.rd_valid), 32'd1);
         check({tag, "_data"},  32'(sif.rd_data),  32'(e[i]));
      end
      sif.dump = 1'b0;
      tick();
      check({tag, "_done"},      32'({sif.dump_done, sif.rd_valid, sif.busy}), 32'b101);
      tick();
      check({tag, "_after"},     32'({sif.dump_done, sif.busy, sif.empty}), 32'b001);
   endtask

   logic [7:0] exp3 [3];
   logic [7:0] exp5 [5];

   initial begin
      reset         = 1'b1;
      sif.load      = 1'b0;
      sif.number_in = '0;
      sif.rd_req    = 1'b0;
      sif.dump      = 1'b0;
      tick();
      tick();
      // {rd_valid, busy, dump_done, full, empty, overflow, underflow}
      check("reset_flags", 32'({sif.rd_valid, sif.busy, sif.dump_done, sif.full, sif.empty,
                                sif.overflow, sif.underflow}), 32'b0000100);
      check("reset_count", 32'(sif.count), 32'd0);
      check("reset_data",  32'(sif.rd_data), 32'd0);
      reset = 1'b0;

      // Three loads then three single reads.
      sif.load = 1'b1;
      sif.number_in = 8'h11; tick();
      sif.number_in = 8'h22; tick();
      sif.number_in = 8'h33; tick();
      sif.load = 1'b0;
      check("t1_count3", 32'(sif.count), 32'd3);
      exp3 = '{8'h11, 8'h22, 8'h33};
      sif.rd_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t1_rd_valid", 32'(sif.rd_valid), 32'd1);
         check("t1_rd_data",  32'(sif.rd_data),  32'(exp3[i]));
      end
      sif.rd_req = 1'b0;
      tick();
      check("t1_idle_valid", 32'(sif.rd_valid), 32'd0);
      check("t1_hold_data",  32'(sif.rd_data), 32'h33);
      check("t1_empty",      32'({sif.count, sif.empty}), 32'b0001);

      // Six loads into a five-entry store; the sixth is dropped.
      sif.load = 1'b1;
      for (int i = 0; i < 6; i++) begin
         sif.number_in = 8'hA0 + 8'(i);
         tick();
         if (i == 4) check("t2_full_at5", 32'({sif.full, sif.count}), 32'b1101);
      end
      sif.load = 1'b0;
      check("t2_overflow", 32'({sif.overflow, sif.full, sif.count}), 32'b11101);
      exp5 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
      dump_and_check("t2_dump", exp5);

      // Wrap through the last index with a leftover entry.
      reset = 1'b1; tick(); reset = 1'b0;
      check("t3_ovf_cleared", 32'(sif.overflow), 32'd0);
      load_bytes(8'hC0, 4);
      sif.rd_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t3_rd_data", 32'(sif.rd_data), 32'(8'hC0 + 8'(i)));
      end
      sif.rd_req = 1'b0;
      load_bytes(8'hB0, 4);
      check("t3_full_no_ovf", 32'({sif.full, sif.overflow, sif.count}), 32'b10101);
      exp5 = '{8'hC3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
      dump_and_check("t3_dump", exp5);

      // Full with a simultaneous load and read.
      load_bytes(8'hD0, 5);
      check("t4_full", 32'(sif.full), 32'd1);
      sif.load = 1'b1; sif.rd_req = 1'b1; sif.number_in = 8'h5A;
      tick();
      sif.load = 1'b0; sif.rd_req = 1'b0;
      check("t4_rw_data",  32'({sif.rd_valid, sif.rd_data}), 32'h1D0);
      check("t4_rw_flags", 32'({sif.overflow, sif.full, sif.count}), 32'b01101);
      tick();
      exp5 = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'h5A};
      dump_and_check("t4_dump", exp5);

      // Read while empty, with a write in the same cycle; then an empty dump.
      sif.rd_req = 1'b1; sif.load = 1'b1; sif.number_in = 8'h77;
      tick();
      sif.rd_req = 1'b0; sif.load = 1'b0;
      check("t5_underflow", 32'({sif.underflow, sif.rd_valid, sif.count}), 32'b10001);
      sif.rd_req = 1'b1;
      tick();
      sif.rd_req = 1'b0;
      check("t5_read_back", 32'({sif.rd_valid, sif.rd_data}), 32'h177);
      check("t5_drained",   32'({sif.empty, sif.count}), 32'b1000);
      sif.dump = 1'b1;
      tick();
      sif.dump = 1'b0;
      check("t5_empty_dump", 32'({sif.dump_done, sif.rd_valid, sif.busy}), 32'b101);
      tick();
      check("t5_dump_end",   32'({sif.dump_done, sif.busy}), 32'b00);

      // Reset in the second cycle of a five-entry dump aborts it.
      reset = 1'b1; tick(); reset = 1'b0;
      check("t6_unf_cleared", 32'(sif.underflow), 32'd0);
      load_bytes(8'hE0, 5);
      sif.dump = 1'b1;
      tick();
      sif.dump = 1'b0;
      check("t6_first", 32'({sif.rd_valid, sif.rd_data}), 32'h1E0);
      tick();
      check("t6_second", 32'({sif.rd_valid, sif.rd_data}), 32'h1E1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_aborted", 32'({sif.rd_valid, sif.busy, sif.empty, sif.count}), 32'b001000);
      for (int i = 0; i < 3; i++) begin
         check("t6_no_done", 32'(sif.dump_done), 32'd0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stim_capture_responder.md
Name: stim_capture_responder

Overview:
- Receiving end of the stimulus load/number interface: captures each byte the stimulus generator drives while load is high into a small circular store.
- Returns captured bytes either one per read request, or as a complete burst (dump) to a checker.
- Sits between the stimulus generator and the bench checker/monitor.

Parameters:
- WIDTH, 8, data width of number_in and rd_data.
- DEPTH, 5, number of storage entries; need not be a power of two.
- PTR_W, 3, pointer/count width; must satisfy 2**PTR_W > DEPTH.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  write strobe from the stimulus generator.
- number_in  input  WIDTH  data captured when load is accepted.
- rd_req  input  1  single-entry read request; honoured in IDLE only.
- dump  input  1  pulse; starts a burst read-out of the stored entries.
- rd_data  output  WIDTH  read data; holds its last value when rd_valid=0.
- rd_valid  output  1  registered; high for exactly the cycles carrying data.
- busy  output  1  high in DUMP and DONE.
- dump_done  output  1  one-cycle pulse that ends a dump.
- count  output  PTR_W  number of stored entries, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- overflow  output  1  sticky; a load was dropped.
- underflow  output  1  sticky; an rd_req was made with nothing to read.

Behaviour:
- Reset (synchronous, on a clk edge with reset=1):
  - state=IDLE; wr_ptr=rd_ptr=0; count=0.
  - rd_data=0, rd_valid=0, busy=0, dump_done=0, overflow=0, underflow=0, full=0, empty=1.
  - Storage contents become don't-care.
  - Reset overrides every other input in the same cycle. A reset during a dump aborts it with no dump_done.
- Pointers:
  - Each pointer advances by 1 and wraps from DEPTH-1 to 0.
  - Never compare pointers modulo 2**PTR_W.
- Write (accepted in any state):
  - load=1 and count<DEPTH: mem[wr_ptr]<=number_in, wr_ptr advances, count increments.
  - load=1 while full, with no read in the same cycle: the write is dropped, overflow<=1, and nothing else changes.
- Single read:
  - IDLE, rd_req=1, count>0: next cycle rd_valid=1 and rd_data=mem[rd_ptr]; rd_ptr advances and count decrements. Latency is 1 cycle.
  - rd_req=1 while empty: underflow<=1, rd_valid stays 0, and a write in the same cycle is still accepted.
  - rd_req outside IDLE is ignored and does not set underflow.
- Simultaneous read and write in one cycle:
  - Both take effect and count is unchanged.
  - When full, the write uses the slot freed by the read, so there is no overflow.
- FSM states: IDLE, DUMP, DONE.
  - IDLE -> DUMP: on dump=1 with count>0. Latch remaining<=count at entry; dump takes priority over rd_req in the same cycle.
  - IDLE -> DONE: on dump=1 with count==0.
  - DUMP: each cycle emit mem[rd_ptr] with rd_valid=1, advance rd_ptr, decrement count and remaining. When remaining reaches 1 (the last emit) -> DONE.
  - Writes accepted during DUMP are not part of the burst, because remaining was latched at entry.
  - DONE: dump_done=1 for one cycle, rd_valid=0 -> IDLE.
  - A dump asserted while busy is ignored.
- Timing of outputs:
  - A burst of N entries gives rd_valid on N consecutive cycles starting the cycle after dump, followed by dump_done on the next cycle.
  - full, empty and count are registered and consistent in the same cycle.
  - overflow and underflow clear only on reset.

Test Plan:
- Reset, then load 0x11, 0x22, 0x33 on consecutive cycles, then rd_req for 3 cycles -> rd_valid on the following 3 cycles carrying 0x11, 0x22, 0x33; count ends at 0 and empty=1.
- Load 6 bytes 0xA0..0xA5 with no reads -> full=1 after the 5th byte; the 6th is dropped and overflow=1; a dump returns 0xA0..0xA4 on 5 consecutive rd_valid cycles, then a dump_done pulse.
- Wrap: load 4 bytes, read 3, load 4 more (0xB0..0xB3) -> wr_ptr wraps through index 4 to 0; a dump returns the leftover byte followed by 0xB0..0xB3 in order; no overflow.
- Full plus simultaneous load=1/rd_req=1 with number_in=0x5A -> the oldest byte is returned, count stays 5, overflow stays 0, and 0x5A is last in the next dump.
- rd_req while empty -> underflow=1 and no rd_valid; dump while empty -> dump_done one cycle later with no rd_valid.
- Assert reset in the 2nd cycle of a 5-entry dump -> the next cycle shows rd_valid=0, busy=0, count=0, empty=1, and dump_done never pulses.
